// File: rtl/m_event_pkg.sv
// Shared constants and bit-counting helpers for the 8-line event encoder.
package m_event_pkg;
  localparam int N_LINES = 8;
  localparam int IDX_W   = 3;
  localparam logic [IDX_W-1:0] RR_RESET_LAST = 3'd7;

  function automatic logic [3:0] f_popcount8(input logic [7:0] v);
    logic [3:0] c;
    c = '0;
    for (int i = 0; i < 8; i++) c = c + {3'b000, v[i]};
    return c;
  endfunction

  function automatic logic f_is_onehot8(input logic [7:0] v);
    return f_popcount8(v) == 4'd1;
  endfunction
endpackage

// File: rtl/m_rr_pick8.sv
// Combinational round-robin picker: rotate so the search start sits at bit 0,
// find the lowest set bit, then rotate the position back.
module m_rr_pick8
  import m_event_pkg::*;
(
  input  logic [N_LINES-1:0] i_req,
  input  logic [IDX_W-1:0]   i_last,
  output logic               o_any,
  output logic [IDX_W-1:0]   o_idx,
  output logic [N_LINES-1:0] o_grant
);
  logic [IDX_W-1:0]     w_start;
  logic [2*N_LINES-1:0] w_dbl;
  logic [N_LINES-1:0]   w_rot;
  logic [IDX_W-1:0]     w_pos;

  // 3-bit add wraps 7 -> 0 on its own
  assign w_start = i_last + IDX_W'(1);
  assign w_dbl   = {i_req, i_req} >> w_start;
  assign w_rot   = w_dbl[N_LINES-1:0];

  always_comb begin
    w_pos = '0;
    for (int i = N_LINES - 1; i >= 0; i--) begin
      if (w_rot[i]) w_pos = IDX_W'(i);
    end
  end

  assign o_any   = |i_req;
  assign o_idx   = w_pos + w_start;
  assign o_grant = o_any ? (N_LINES'(1) << o_idx) : '0;
endmodule

// File: rtl/m_8x3_event_encoder.sv
// Captures one-hot decoder events into a pending set and drains them one at a
// time as a 3-bit index over a valid/ready slot with round-robin fairness.
module m_8x3_event_encoder
  import m_event_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic [N_LINES-1:0] in_line,
  input  logic               in_valid,
  output logic [IDX_W-1:0]   out_idx,
  output logic               out_valid,
  input  logic               out_ready,
  input  logic               err_clr,
  output logic [N_LINES-1:0] pending,
  output logic               onehot_err,
  output logic               overflow
);
  logic [N_LINES-1:0] r_pending;
  logic [IDX_W-1:0]   r_idx;
  logic [IDX_W-1:0]   r_last;
  logic               r_valid;
  logic               r_onehot_err;
  logic               r_overflow;

  logic [N_LINES-1:0] w_cap;
  logic [N_LINES-1:0] w_cand;
  logic               w_slot_free;
  logic               w_new_oh;
  logic               w_new_ov;
  logic               w_any;
  logic [IDX_W-1:0]   w_idx;
  logic [N_LINES-1:0] w_grant;

  assign w_cap       = in_valid ? in_line : '0;
  // Captured lines bypass straight into the arbitration so a free slot loads on the same edge
  assign w_cand      = r_pending | w_cap;
  assign w_slot_free = !r_valid || out_ready;
  assign w_new_oh    = in_valid && !f_is_onehot8(in_line);
  assign w_new_ov    = |(w_cap & r_pending);

  m_rr_pick8 u_pick (
    .i_req   (w_cand),
    .i_last  (r_last),
    .o_any   (w_any),
    .o_idx   (w_idx),
    .o_grant (w_grant)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_pending    <= '0;
      r_idx        <= '0;
      r_last       <= RR_RESET_LAST;
      r_valid      <= 1'b0;
      r_onehot_err <= 1'b0;
      r_overflow   <= 1'b0;
    end else begin
      // A fresh error in the clearing cycle still sets the bit
      r_onehot_err <= (r_onehot_err && !err_clr) || w_new_oh;
      r_overflow   <= (r_overflow && !err_clr) || w_new_ov;
      if (w_slot_free) begin
        r_valid   <= w_any;
        r_pending <= w_cand & ~w_grant;
        if (w_any) begin
          r_idx  <= w_idx;
          r_last <= w_idx;
        end
      end else begin
        r_pending <= w_cand;
      end
    end
  end

  assign out_idx    = r_idx;
  assign out_valid  = r_valid;
  assign pending    = r_pending;
  assign onehot_err = r_onehot_err;
  assign overflow   = r_overflow;
endmodule

// File: tb/tb_m_8x3_event_encoder.sv
// Directed and randomized bench for m_8x3_event_encoder with a queue-free
// behavioural model of the pending set, output slot and sticky error bits.
module tb_m_8x3_event_encoder;
  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] in_line = '0;
  logic       in_valid = 1'b0;
  logic [2:0] out_idx;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic       err_clr = 1'b0;
  logic [7:0] pending;
  logic       onehot_err;
  logic       overflow;

  int n_chk = 0;
  int n_fail = 0;

  // model state
  logic [7:0] m_pend;
  logic       m_valid;
  logic [2:0] m_idx;
  int         m_last;
  logic       m_oh;
  logic       m_ov;

  m_8x3_event_encoder dut (
    .clk        (clk),
    .reset      (reset),
    .in_line    (in_line),
    .in_valid   (in_valid),
    .out_idx    (out_idx),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .err_clr    (err_clr),
    .pending    (pending),
    .onehot_err (onehot_err),
    .overflow   (overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_step(logic rst, logic [7:0] ln, logic v, logic rdy, logic clr);
    logic [7:0] cap, cand;
    logic new_oh, new_ov;
    int sel;
    if (rst) begin
      m_pend = '0; m_valid = 1'b0; m_idx = '0; m_last = 7; m_oh = 1'b0; m_ov = 1'b0;
    end else begin
      cap    = v ? ln : 8'h00;
      new_oh = v && ($countones(ln) != 1);
      new_ov = (cap & m_pend) != 8'h00;
      cand   = m_pend | cap;
      if (!m_valid || rdy) begin
        sel = -1;
        for (int k = 1; k <= 8; k++) begin
          if (sel < 0 && cand[(m_last + k) % 8]) sel = (m_last + k) % 8;
        end
        if (sel >= 0) begin
          m_valid = 1'b1; m_idx = 3'(sel); m_last = sel; cand[sel] = 1'b0;
        end else begin
          m_valid = 1'b0;
        end
      end
      m_pend = cand;
      m_oh = new_oh || (m_oh && !clr);
      m_ov = new_ov || (m_ov && !clr);
    end
  endtask

  task automatic step(logic rst, logic [7:0] ln, logic v, logic rdy, logic clr);
    reset = rst; in_line = ln; in_valid = v; out_ready = rdy; err_clr = clr;
    model_step(rst, ln, v, rdy, clr);
    @(posedge clk);
    #1;
    chk("out_valid", 32'(out_valid), 32'(m_valid));
    chk("out_idx", 32'(out_idx), 32'(m_idx));
    chk("pending", 32'(pending), 32'(m_pend));
    chk("onehot_err", 32'(onehot_err), 32'(m_oh));
    chk("overflow", 32'(overflow), 32'(m_ov));
  endtask

  initial begin
    logic [7:0] ln;
    int r;

    // reset and single event
    step(1, 8'h00, 0, 1, 0);
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_idx", 32'(out_idx), 32'd0);
    chk("rst_pending", 32'(pending), 32'd0);
    step(0, 8'b0000_0100, 1, 1, 0);
    chk("single_valid", 32'(out_valid), 32'd1);
    chk("single_idx", 32'(out_idx), 32'd2);
    step(0, 8'h00, 0, 1, 0);
    chk("single_drain", 32'(out_valid), 32'd0);
    chk("single_noerr", 32'({onehot_err, overflow}), 32'd0);

    // backpressure with fairness
    step(1, 8'h00, 0, 0, 0);
    step(0, 8'h01, 1, 0, 0);
    chk("bp_first_idx", 32'(out_idx), 32'd0);
    step(0, 8'h80, 1, 0, 0);
    step(0, 8'h10, 1, 0, 0);
    chk("bp_pending", 32'(pending), 32'h90);
    step(0, 8'h00, 0, 1, 0);
    chk("bp_out4", 32'(out_idx), 32'd4);
    step(0, 8'h00, 0, 1, 0);
    chk("bp_out7", 32'(out_idx), 32'd7);
    step(0, 8'h00, 0, 1, 0);
    chk("bp_empty", 32'(out_valid), 32'd0);

    // wrap-around from last=6, re-capturing the line held in the slot
    step(1, 8'h00, 0, 1, 0);
    step(0, 8'h40, 1, 1, 0);
    step(0, 8'h40, 1, 0, 0);
    step(0, 8'h01, 1, 0, 0);
    chk("wrap_pending", 32'(pending), 32'h41);
    chk("wrap_no_ov", 32'(overflow), 32'd0);
    step(0, 8'h00, 0, 1, 0);
    chk("wrap_idx0", 32'(out_idx), 32'd0);
    step(0, 8'h00, 0, 1, 0);
    chk("wrap_idx6", 32'(out_idx), 32'd6);

    // malformed input
    step(1, 8'h00, 0, 0, 0);
    step(0, 8'h01, 1, 0, 0);
    step(0, 8'b0011_0000, 1, 0, 0);
    chk("multi_err", 32'(onehot_err), 32'd1);
    chk("multi_pending", 32'(pending), 32'h30);
    step(0, 8'h00, 0, 0, 1);
    chk("oh_clr", 32'(onehot_err), 32'd0);
    step(0, 8'h00, 1, 0, 0);
    chk("zero_err", 32'(onehot_err), 32'd1);
    chk("zero_pending", 32'(pending), 32'h30);

    // overflow and clear
    step(1, 8'h00, 0, 0, 0);
    step(0, 8'h01, 1, 0, 0);
    step(0, 8'h02, 1, 0, 0);
    step(0, 8'h02, 1, 0, 0);
    chk("ov_set", 32'(overflow), 32'd1);
    step(0, 8'h00, 0, 0, 1);
    chk("ov_clr", 32'(overflow), 32'd0);
    step(0, 8'h02, 1, 0, 1);
    chk("ov_clr_collide", 32'(overflow), 32'd1);

    // reset mid-operation
    step(1, 8'h00, 0, 0, 0);
    step(0, 8'h01, 1, 0, 0);
    step(0, 8'h10, 1, 0, 0);
    step(0, 8'h20, 1, 0, 0);
    step(0, 8'h40, 1, 0, 0);
    step(0, 8'h80, 1, 0, 0);
    chk("mid_pending", 32'(pending), 32'hF0);
    step(1, 8'h00, 0, 0, 0);
    chk("mid_rst", 32'({out_valid, out_idx, pending, onehot_err, overflow}), 32'd0);
    step(0, 8'h81, 1, 0, 0);
    chk("mid_first", 32'(out_idx), 32'd0);

    // randomized traffic
    for (int n = 0; n < 400; n++) begin
      r = int'($urandom_range(0, 15));
      if (r < 11)      ln = 8'b1 << $urandom_range(0, 7);
      else if (r < 14) ln = 8'($urandom);
      else             ln = 8'h00;
      step($urandom_range(0, 49) == 0, ln, $urandom_range(0, 3) != 0,
           $urandom_range(0, 2) != 0, $urandom_range(0, 9) == 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
